// File: rtl/video_native_to_axis_pkg.sv
// Shared types for the native-video to AXI4-Stream bridge.
//   v2a_state_e : capture FSM states
//   V2A_BEAT_T  : macro building the {user, last, data} beat struct for a given width
//   v2a_beat_t  : beat struct at the default 24-bit pixel width
`ifndef V2A_BEAT_T
`define V2A_BEAT_T(W) struct packed { logic user; logic last; logic [(W)-1:0] data; }
`endif

package video_native_to_axis_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        ACTIVE  = 2'd2,
        DROP    = 2'd3
    } v2a_state_e;

    localparam int V2A_DSIZE_DEFAULT = 24;

    typedef `V2A_BEAT_T(V2A_DSIZE_DEFAULT) v2a_beat_t;

endpackage

// File: rtl/video_native_to_axis_stream_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered output word.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   wr_en_i/wr_data_i : write request; ignored while full_o=1
//   full_o            : storage array is full
//   rd_en_i           : consumer accepts the current output word
//   rd_data_o/valid_o : registered output word and its valid flag
//   empty_o           : nothing stored and nothing presented
module stream_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             full_o,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             valid_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             mem_empty_s;
    logic             mem_full_s;
    logic             wr_s;
    logic             pop_s;

    // Extra pointer MSB separates full from empty when the index bits match.
    assign mem_empty_s = (wptr_q == rptr_q);
    assign mem_full_s  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign wr_s        = wr_en_i & ~mem_full_s;
    // Refill the output register when it is empty or being consumed this cycle.
    assign pop_s       = ~mem_empty_s & (~valid_q | rd_en_i);

    assign full_o    = mem_full_s;
    assign rd_data_o = data_q;
    assign valid_o   = valid_q;
    assign empty_o   = mem_empty_s & ~valid_q;

    // Storage array write port (contents need no reset).
    always_ff @(posedge clk_i) begin
        if (wr_s) begin
            mem_q[wptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    // Pointers and the registered output word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (wr_s) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop_s) begin
                rptr_q  <= rptr_q + 1'b1;
                data_q  <= mem_q[rptr_q[AW-1:0]];
                valid_q <= 1'b1;
            end else if (rd_en_i) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/video_native_to_axis.sv
// Native video (vsync/hsync/de/data) to AXI4-Stream master bridge for VDMA write.
//   pclk, prst        : pixel clock, synchronous active-high reset
//   enable            : capture enable, acted on at frame start
//   vsync/hsync/de/data : native video input (hsync is not used for framing)
//   hactive           : expected pixels per line for the length check
//   m_t*              : AXIS master (tuser = start of frame, tlast = end of line)
//   overflow, len_err : sticky error flags
module video_native_to_axis
    import video_native_to_axis_pkg::*;
#(
    parameter int DSIZE      = 24,
    parameter int FIFO_DEPTH = 16,
    parameter bit VS_POL     = 1'b1
) (
    input  logic             pclk,
    input  logic             prst,
    input  logic             enable,
    input  logic             vsync,
    input  logic             hsync,
    input  logic             de,
    input  logic [DSIZE-1:0] data,
    input  logic [15:0]      hactive,
    output logic [DSIZE-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tuser,
    output logic             m_tlast,
    output logic             overflow,
    output logic             len_err
);
    typedef `V2A_BEAT_T(DSIZE) beat_t;

    v2a_state_e       state_q, state_d;
    logic             vs_prev_q;
    logic             vs_act_s, vs_rise_s, qualify_s, capture_s;
    logic             stage_vld_q, stage_vld_d;
    logic             stage_user_q, stage_user_d;
    logic [DSIZE-1:0] stage_data_q, stage_data_d;
    logic             sof_pend_q, sof_pend_d;
    logic [15:0]      pix_cnt_q, pix_cnt_d;
    logic             overflow_q, overflow_d;
    logic             len_err_q, len_err_d;
    logic             fifo_full_s, wr_en_s, ovf_evt_s, last_s;
    logic             fifo_valid_s, fifo_unused_empty_s, hsync_unused_s;
    beat_t            wr_beat_s, rd_beat_s;

    assign hsync_unused_s = hsync;

    assign vs_act_s  = (vsync == VS_POL);
    assign vs_rise_s = vs_act_s & ~vs_prev_q;
    // A vs_rise only opens a frame when armed and still enabled.
    assign qualify_s = vs_rise_s & enable & ((state_q == WAIT_VS) || (state_q == ACTIVE));
    // vs_rise wins over de: a pixel coinciding with a non-qualifying rise is ignored.
    assign capture_s = de & (qualify_s | ((state_q == ACTIVE) & ~vs_rise_s));

    // The staged pixel is always written one cycle after capture; its EOL is
    // known only now, by looking at the pixel that follows it.
    assign last_s    = ~de | vs_rise_s;
    assign ovf_evt_s = stage_vld_q & fifo_full_s;
    assign wr_en_s   = stage_vld_q & ~fifo_full_s;

    // Beat presented to the FIFO.
    always_comb begin
        wr_beat_s      = '0;
        wr_beat_s.user = stage_user_q;
        wr_beat_s.last = last_s;
        wr_beat_s.data = stage_data_q;
    end

    // Capture FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable) state_d = WAIT_VS;
                else        state_d = IDLE;
            end
            WAIT_VS: begin
                if (!enable)        state_d = IDLE;
                else if (vs_rise_s) state_d = ACTIVE;
                else                state_d = WAIT_VS;
            end
            ACTIVE: begin
                if (ovf_evt_s)                state_d = DROP;
                else if (vs_rise_s && !enable) state_d = WAIT_VS;
                else                          state_d = ACTIVE;
            end
            DROP:    state_d = WAIT_VS;
            default: state_d = IDLE;
        endcase
    end

    // Stage register, SOF pending flag, line counter and sticky flags.
    always_comb begin
        stage_vld_d  = capture_s & ~ovf_evt_s;
        stage_user_d = stage_user_q;
        stage_data_d = stage_data_q;
        sof_pend_d   = sof_pend_q;
        pix_cnt_d    = pix_cnt_q;
        overflow_d   = overflow_q | ovf_evt_s;
        len_err_d    = len_err_q;
        if (capture_s) begin
            stage_user_d = qualify_s | sof_pend_q;
            stage_data_d = data;
        end else begin
            stage_user_d = stage_user_q;
        end
        if (ovf_evt_s) begin
            sof_pend_d = 1'b0;
        end else if (qualify_s) begin
            sof_pend_d = ~de;
        end else if (capture_s) begin
            sof_pend_d = 1'b0;
        end else begin
            sof_pend_d = sof_pend_q;
        end
        // A broken line is abandoned, so its partial count must not be checked.
        if (ovf_evt_s) begin
            pix_cnt_d = 16'd0;
        end else if (wr_en_s && last_s) begin
            pix_cnt_d = 16'd0;
            len_err_d = len_err_q | ((pix_cnt_q + 16'd1) != hactive);
        end else if (wr_en_s) begin
            pix_cnt_d = pix_cnt_q + 16'd1;
        end else begin
            pix_cnt_d = pix_cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q      <= IDLE;
            vs_prev_q    <= 1'b0;
            stage_vld_q  <= 1'b0;
            stage_user_q <= 1'b0;
            stage_data_q <= '0;
            sof_pend_q   <= 1'b0;
            pix_cnt_q    <= 16'd0;
            overflow_q   <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs_prev_q    <= vs_act_s;
            stage_vld_q  <= stage_vld_d;
            stage_user_q <= stage_user_d;
            stage_data_q <= stage_data_d;
            sof_pend_q   <= sof_pend_d;
            pix_cnt_q    <= pix_cnt_d;
            overflow_q   <= overflow_d;
            len_err_q    <= len_err_d;
        end
    end

    stream_sync_fifo #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (pclk),
        .rst_i     (prst),
        .wr_en_i   (wr_en_s),
        .wr_data_i (wr_beat_s),
        .full_o    (fifo_full_s),
        .rd_en_i   (m_tready),
        .rd_data_o (rd_beat_s),
        .valid_o   (fifo_valid_s),
        .empty_o   (fifo_unused_empty_s)
    );

    assign m_tdata  = rd_beat_s.data;
    assign m_tuser  = rd_beat_s.user;
    assign m_tlast  = rd_beat_s.last;
    assign m_tvalid = fifo_valid_s;
    assign overflow = overflow_q;
    assign len_err  = len_err_q;

endmodule
